// File: rtl/boron_pkg.sv
// Shared constants, S-box and FSM encoding for the BORON round core.
package boron_pkg;

   localparam int unsigned BLOCK_W        = 64;
   localparam int unsigned KEY_W          = 80;
   localparam int unsigned RC_W           = 5;
   localparam int unsigned DEFAULT_ROUNDS = 25;

   // Nibble i of SBOX holds S(i).
   localparam logic [63:0] SBOX = 64'h6358_F02D_AC97_1B4E;

   typedef enum logic [1:0] {
      StIdle,
      StRound,
      StFinal,
      StDone
   } state_e;

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      return SBOX[{x, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/boron_block_shuffle.sv
// Byte-level shuffle: output byte k takes input byte k^5.
module boron_block_shuffle
   import boron_pkg::*;
(
   input  logic [BLOCK_W-1:0] state_i,
   output logic [BLOCK_W-1:0] state_o
);

   assign state_o = {state_i[23:16], state_i[31:24], state_i[7:0],   state_i[15:8],
                     state_i[55:48], state_i[63:56], state_i[39:32], state_i[47:40]};

endmodule

// File: rtl/boron_key_update.sv
// One key-schedule step: rotate left 13, S-box the low nibble, fold in the round counter.
module boron_key_update
   import boron_pkg::*;
(
   input  logic [KEY_W-1:0] key_in,
   input  logic [RC_W-1:0]  rc,
   output logic [KEY_W-1:0] key_out
);

   logic [KEY_W-1:0] rot;

   always_comb begin
      rot           = {key_in[KEY_W-14:0], key_in[KEY_W-1:KEY_W-13]};
      key_out       = rot;
      key_out[3:0]  = sbox4(rot[3:0]);
      key_out[63:59] = rot[63:59] ^ rc;
   end

endmodule

// File: rtl/boron_round_perm.sv
// Rotates the four 16-bit words left by 9, 7, 4 and 1 (most to least significant).
module boron_round_perm
   import boron_pkg::*;
(
   input  logic [BLOCK_W-1:0] state_i,
   output logic [BLOCK_W-1:0] state_o
);

   assign state_o = {state_i[54:48], state_i[63:55],
                     state_i[40:32], state_i[47:41],
                     state_i[27:16], state_i[31:28],
                     state_i[14:0],  state_i[15]};

endmodule

// File: rtl/boron_sbox_layer.sv
// Sixteen parallel 4-bit S-boxes across the 64-bit state.
module boron_sbox_layer
   import boron_pkg::*;
(
   input  logic [BLOCK_W-1:0] state_i,
   output logic [BLOCK_W-1:0] state_o
);

   always_comb begin
      state_o = '0;
      for (int i = 0; i < 16; i++) begin
         state_o[4*i +: 4] = sbox4(state_i[4*i +: 4]);
      end
   end

endmodule

// File: rtl/boron_xor_layer.sv
// Word-wise XOR diffusion; w3 is the most significant 16-bit word.
module boron_xor_layer
   import boron_pkg::*;
(
   input  logic [BLOCK_W-1:0] state_i,
   output logic [BLOCK_W-1:0] state_o
);

   logic [15:0] w3, w2, w1, w0;
   logic [15:0] o3, o2, o1, o0;

   always_comb begin
      {w3, w2, w1, w0} = state_i;
      o3 = w3 ^ w1;
      o2 = w2 ^ w0;
      o1 = w1 ^ o2;
      o0 = w0 ^ o3;
      state_o = {o3, o2, o1, o0};
   end

endmodule

// File: rtl/boron_round_core.sv
// Iterative BORON encryption core: one round per clock, valid/ready on both sides.
module boron_round_core
   import boron_pkg::*;
#(
   parameter int unsigned ROUNDS = DEFAULT_ROUNDS,
   parameter int unsigned KEY_W  = boron_pkg::KEY_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BLOCK_W-1:0] plaintext,
   input  logic [KEY_W-1:0]   key,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] ciphertext,
   output logic               busy
);

   localparam logic [RC_W-1:0] LAST_RC = RC_W'(ROUNDS - 1);

   state_e             st_q, st_d;
   logic [BLOCK_W-1:0] state_q, state_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [RC_W-1:0]    rc_q, rc_d;
   logic               valid_q, valid_d;
   logic               rst_sync_q;

   logic [BLOCK_W-1:0] ark, sb, sh, pm, rnd;
   logic [KEY_W-1:0]   key_next;
   logic [RC_W-1:0]    rc_inc;

   assign ark    = state_q ^ key_q[63:0];
   assign rc_inc = rc_q + 1'b1;

   boron_sbox_layer u_sbox (
      .state_i (ark),
      .state_o (sb)
   );

   boron_block_shuffle u_shuffle (
      .state_i (sb),
      .state_o (sh)
   );

   boron_round_perm u_perm (
      .state_i (sh),
      .state_o (pm)
   );

   boron_xor_layer u_xor (
      .state_i (pm),
      .state_o (rnd)
   );

   boron_key_update u_key_update (
      .key_in  (key_q),
      .rc      (rc_inc),
      .key_out (key_next)
   );

   always_comb begin
      st_d    = st_q;
      state_d = state_q;
      key_d   = key_q;
      rc_d    = rc_q;
      valid_d = valid_q;
      unique case (st_q)
         StIdle: begin
            // Accepts are held off until the synchronised reset release lands.
            if (in_valid && rst_sync_q) begin
               state_d = plaintext;
               key_d   = key;
               rc_d    = '0;
               st_d    = StRound;
            end
         end
         StRound: begin
            state_d = rnd;
            key_d   = key_next;
            rc_d    = rc_inc;
            if (rc_q == LAST_RC) begin
               st_d = StFinal;
            end
         end
         StFinal: begin
            state_d = state_q ^ key_q[63:0];
            st_d    = StDone;
         end
         StDone: begin
            // out_valid rises one edge after entering DONE.
            valid_d = 1'b1;
            if (valid_q && out_ready) begin
               valid_d = 1'b0;
               st_d    = StIdle;
            end
         end
         default: st_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= 1'b0;
         st_q       <= StIdle;
         state_q    <= '0;
         key_q      <= '0;
         rc_q       <= '0;
         valid_q    <= 1'b0;
      end else begin
         rst_sync_q <= 1'b1;
         st_q       <= st_d;
         state_q    <= state_d;
         key_q      <= key_d;
         rc_q       <= rc_d;
         valid_q    <= valid_d;
      end
   end

   assign in_ready   = (st_q == StIdle);
   assign busy       = (st_q != StIdle);
   assign out_valid  = valid_q;
   assign ciphertext = state_q;

endmodule
